// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU line fetcher: FSM states, VRAM bases
// and the OAM sprite hit test.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OAM_SCAN,
    BG_MAP,
    BG_LO,
    BG_HI,
    BG_PUSH,
    DONE
  } ppu_state_e;

  localparam logic [12:0] MAP0_BASE        = 13'h1800;
  localparam logic [12:0] MAP1_BASE        = 13'h1C00;
  localparam logic [12:0] TILE_SIGNED_BASE = 13'h1000;
  localparam int          OAM_ENTRIES      = 40;

  // 9-bit compare so that Y values near 255 cannot wrap into a false hit.
  function automatic logic sprite_hit(input logic [7:0] ly, input logic [7:0] y,
                                      input logic tall);
    logic [8:0] ly16;
    logic [8:0] y_end;
    ly16  = {1'b0, ly} + 9'd16;
    y_end = {1'b0, y} + (tall ? 9'd16 : 9'd8);
    return (ly16 >= {1'b0, y}) && (ly16 < y_end);
  endfunction

endpackage

// File: rtl/ppu_fetcher_bg_addr.sv
// Combinational background address generator: tile-map entry address and
// tile-data (low plane) address for the current line and tile column.
module ppu_bg_addr
  import ppu_pkg::*;
(
  input  logic [7:0]  ly,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic        lcdc_bg_map,
  input  logic        lcdc_tile_data,
  input  logic [4:0]  tile_col,
  input  logic [7:0]  tile_idx,
  output logic [12:0] map_addr,
  output logic [12:0] data_addr
);

  logic [7:0]  line_y;
  logic [4:0]  map_col;
  logic [12:0] tile_base;

  always_comb begin
    line_y   = ly + scy;
    map_col  = scx[7:3] + tile_col;
    map_addr = (lcdc_bg_map ? MAP1_BASE : MAP0_BASE) + {3'b000, line_y[7:3], map_col};
    // Signed mode: tile index is two's complement around 0x1000, wrapping in 13 bits.
    if (lcdc_tile_data) begin
      tile_base = {1'b0, tile_idx, 4'b0000};
    end else begin
      tile_base = TILE_SIGNED_BASE + {tile_idx[7], tile_idx, 4'b0000};
    end
    data_addr = tile_base + {9'b0, line_y[2:0], 1'b0};
  end

endmodule

// File: rtl/ppu_fetcher.sv
// Per-scanline PPU fetcher: scans OAM for sprite hits, then fetches background
// tile rows and hands each one downstream over a valid/ready handshake.
module ppu_fetcher
  import ppu_pkg::*;
#(
  parameter int TILES_PER_LINE = 21,
  parameter int MAX_SPRITES    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  ly,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic        lcdc_bg_map,
  input  logic        lcdc_tile_data,
  input  logic        lcdc_obj_size,
  output logic [12:0] ppu_addr,
  output logic        ppu_oam_read_en,
  output logic        ppu_vram_read_en,
  output logic        ppu_read_mode,
  input  logic [7:0]  ppu_data_in,
  output logic        spr_found,
  output logic [5:0]  spr_index,
  output logic [7:0]  spr_x,
  output logic [3:0]  spr_row,
  output logic [3:0]  sprite_count,
  output logic        row_valid,
  input  logic        row_ready,
  output logic [7:0]  row_lo,
  output logic [7:0]  row_hi,
  output logic [1:0]  mode,
  output ppu_state_e  dbg_state
);

  ppu_state_e  state_q, state_d;
  logic        phase_q, phase_d;
  logic [6:0]  scan_q, scan_d;
  logic [7:0]  tile_col_q, tile_col_d;
  logic [7:0]  tile_q, tile_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  row_lo_q, row_lo_d;
  logic [7:0]  row_hi_q, row_hi_d;
  logic        spr_found_q, spr_found_d;
  logic [5:0]  spr_index_q, spr_index_d;
  logic [7:0]  spr_x_q, spr_x_d;
  logic [3:0]  spr_row_q, spr_row_d;
  logic [3:0]  count_q, count_d;
  logic [12:0] map_addr, data_addr;
  logic [8:0]  row_diff;

  ppu_bg_addr u_bg_addr (
    .ly             (ly),
    .scx            (scx),
    .scy            (scy),
    .lcdc_bg_map    (lcdc_bg_map),
    .lcdc_tile_data (lcdc_tile_data),
    .tile_col       (tile_col_q[4:0]),
    .tile_idx       (tile_q),
    .map_addr       (map_addr),
    .data_addr      (data_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      scan_q      <= '0;
      tile_col_q  <= '0;
      tile_q      <= '0;
      y_q         <= '0;
      row_lo_q    <= '0;
      row_hi_q    <= '0;
      spr_found_q <= 1'b0;
      spr_index_q <= '0;
      spr_x_q     <= '0;
      spr_row_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      scan_q      <= scan_d;
      tile_col_q  <= tile_col_d;
      tile_q      <= tile_d;
      y_q         <= y_d;
      row_lo_q    <= row_lo_d;
      row_hi_q    <= row_hi_d;
      spr_found_q <= spr_found_d;
      spr_index_q <= spr_index_d;
      spr_x_q     <= spr_x_d;
      spr_row_q   <= spr_row_d;
      count_q     <= count_d;
    end
  end

  // OAM data arrives one cycle after its address: odd scan cycles return Y,
  // even cycles (>0) return X of the entry whose Y was latched just before.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    scan_d      = scan_q;
    tile_col_d  = tile_col_q;
    tile_d      = tile_q;
    y_d         = y_q;
    row_lo_d    = row_lo_q;
    row_hi_d    = row_hi_q;
    spr_found_d = 1'b0;
    spr_index_d = spr_index_q;
    spr_x_d     = spr_x_q;
    spr_row_d   = spr_row_q;
    count_d     = count_q;
    row_diff    = ({1'b0, ly} + 9'd16) - {1'b0, y_q};

    case (state_q)
      OAM_SCAN: begin
        if (scan_q[0]) begin
          y_d = ppu_data_in;
        end else if (scan_q != 7'd0) begin
          if (sprite_hit(ly, y_q, lcdc_obj_size) && (count_q < 4'(MAX_SPRITES))) begin
            spr_found_d = 1'b1;
            spr_index_d = scan_q[6:1] - 6'd1;
            spr_x_d     = ppu_data_in;
            spr_row_d   = row_diff[3:0];
            count_d     = count_q + 4'd1;
          end
        end
        if (scan_q == 7'(2 * OAM_ENTRIES)) begin
          state_d    = BG_MAP;
          phase_d    = 1'b0;
          tile_col_d = '0;
        end else begin
          scan_d = scan_q + 7'd1;
        end
      end
      BG_MAP: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          tile_d  = ppu_data_in;
          state_d = BG_LO;
        end
      end
      BG_LO: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          row_lo_d = ppu_data_in;
          state_d  = BG_HI;
        end
      end
      BG_HI: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          row_hi_d = ppu_data_in;
          state_d  = BG_PUSH;
        end
      end
      // row_valid is high for the whole of BG_PUSH with row_lo/row_hi stable;
      // a row transfers on any rising edge where row_valid and row_ready are both 1.
      BG_PUSH: begin
        if (row_ready) begin
          if (tile_col_q == 8'(TILES_PER_LINE - 1)) begin
            state_d = DONE;
          end else begin
            tile_col_d = tile_col_q + 8'd1;
            state_d    = BG_MAP;
          end
        end
      end
      default: ;
    endcase

    if (line_start) begin
      state_d     = OAM_SCAN;
      phase_d     = 1'b0;
      scan_d      = '0;
      tile_col_d  = '0;
      count_d     = '0;
      spr_found_d = 1'b0;
    end
  end

  always_comb begin
    ppu_addr         = '0;
    ppu_oam_read_en  = 1'b0;
    ppu_vram_read_en = 1'b0;
    ppu_read_mode    = 1'b0;
    mode             = 2'd0;
    case (state_q)
      OAM_SCAN: begin
        ppu_addr        = {5'b0, scan_q[6:1], 1'b0, scan_q[0]};
        ppu_oam_read_en = 1'b1;
        mode            = 2'd2;
      end
      BG_MAP, BG_LO, BG_HI, BG_PUSH: begin
        ppu_vram_read_en = 1'b1;
        ppu_read_mode    = 1'b1;
        mode             = 2'd3;
        if (state_q == BG_MAP) begin
          ppu_addr = map_addr;
        end else if (state_q == BG_LO) begin
          ppu_addr = data_addr;
        end else begin
          ppu_addr = data_addr + 13'd1;
        end
      end
      default: ;
    endcase
  end

  assign spr_found    = spr_found_q;
  assign spr_index    = spr_index_q;
  assign spr_x        = spr_x_q;
  assign spr_row      = spr_row_q;
  assign sprite_count = count_q;
  assign row_valid    = (state_q == BG_PUSH);
  assign row_lo       = row_lo_q;
  assign row_hi       = row_hi_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/ppu_fetcher.md
PPU_FETCHER -- requirements
Module: ppu_fetcher

Interface
REQ-001 SHALL have parameter TILES_PER_LINE, default 21, the number of background tile rows fetched per scanline.
REQ-002 SHALL have parameter MAX_SPRITES, default 10, the maximum number of sprite hits reported per line.
REQ-003 SHALL have ports: clock  in  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 line_start  in  1  one-cycle pulse; begins a scanline.
REQ-006 ly, scx, scy  in  8 each  current line and scroll registers.
REQ-007 lcdc_bg_map, lcdc_tile_data, lcdc_obj_size  in  1 each  LCDC bits 3, 4 and 2.
REQ-008 ppu_addr  out  13  VRAM/OAM read address presented to the memory map.
REQ-009 ppu_oam_read_en, ppu_vram_read_en  out  1 each  CPU-block flags to the memory map.
REQ-010 ppu_read_mode  out  1  0 selects OAM, 1 selects VRAM on the memory map's PPU read mux.
REQ-011 ppu_data_in  in  8  memory read data, valid one cycle after ppu_addr.
REQ-012 spr_found  out  1  pulse; spr_index (6), spr_x (8), spr_row (4) are valid with it.
REQ-013 sprite_count  out  4  hits reported this line.
REQ-014 row_valid  out  1 / row_ready  in  1 / row_lo, row_hi  out  8 each  background tile-row handshake.
REQ-015 mode  out  2  2 = OAM scan, 3 = transfer, 0 = idle/done.

Function
REQ-016 States SHALL be IDLE, OAM_SCAN, BG_MAP, BG_LO, BG_HI, BG_PUSH and DONE; a sub-state bit splits each read into an issue cycle and a capture cycle.
REQ-017 line_start in any state SHALL go to OAM_SCAN on the next cycle, clear sprite_count, drop row_valid and abort any fetch in progress.
REQ-018 OAM_SCAN cycle c (0..79) SHALL drive ppu_addr = 4*(c>>1) + (c&1), i.e. entry Y then X; cycle 80 is a drain cycle; then BG_MAP.
REQ-019 Hit test SHALL use 9-bit arithmetic: (ly+16 >= Y) and (ly+16 < Y+h), where h = 16 if lcdc_obj_size else 8.
REQ-020 For entry i, spr_found SHALL pulse in cycle 2i+3 if the entry hit and sprite_count < MAX_SPRITES.
REQ-021 With that pulse: spr_index = i, spr_x = X byte, spr_row = (ly+16-Y)[3:0]; sprite_count then increments.
REQ-022 BG_MAP address SHALL be base + 32*((ly+scy)[7:3]) + ((scx[7:3]+t) mod 32), with base 0x1800 or 0x1C00 from lcdc_bg_map and t = tile column 0..TILES_PER_LINE-1.
REQ-023 BG_LO address with lcdc_tile_data=1 SHALL be 16*tile + 2*((ly+scy)[2:0]).
REQ-024 With lcdc_tile_data=0 it SHALL be 0x1000 + 16*signed(tile) + 2*((ly+scy)[2:0]), truncated to 13 bits; the BG_HI address is the BG_LO address + 1.
REQ-025 Each read SHALL take 2 cycles: the address is held through the capture cycle and data is latched in the capture cycle.
REQ-026 BG_PUSH SHALL assert row_valid with row_lo/row_hi stable until the cycle row_ready=1 (the transfer).
REQ-027 After the transfer, t increments; the block goes to BG_MAP, or to DONE after TILES_PER_LINE transfers.
REQ-028 In OAM_SCAN (including drain): ppu_oam_read_en=1, ppu_read_mode=0, mode=2.
REQ-029 In BG states: ppu_vram_read_en=1, ppu_read_mode=1, mode=3.
REQ-030 In IDLE and DONE: both enables 0, ppu_read_mode=0, mode=0, ppu_addr=0.
REQ-031 Scroll and LCDC inputs SHALL be sampled live; the line fetch offset is not latched.

Reset
REQ-032 Reset SHALL go to IDLE on the next edge and override line_start.
REQ-033 After reset all outputs SHALL be 0 (ppu_addr, enables, ppu_read_mode, spr_*, sprite_count, row_*, mode).
REQ-034 Reset mid-operation SHALL abandon the line; the block waits for a fresh line_start.

Structure
REQ-035 ppu_pkg SHALL hold the state enum and the constants MAP0_BASE=13'h1800, MAP1_BASE=13'h1C00, TILE_SIGNED_BASE=13'h1000 and OAM_ENTRIES=40.
REQ-036 One combinational sub-module, ppu_bg_addr, SHALL compute the map and tile-data addresses (REQ-022 to REQ-024).

Verification
REQ-037 Entry 3 set to Y=16, X=8; ly=0; obj_size=0 -> single spr_found in cycle 9: index 3, x 8, row 0; sprite_count=1.
REQ-038 Entries 0..11 all set to Y=16, ly=0 -> exactly 10 pulses (indices 0..9); sprite_count=10; entries 10 and 11 are silent.
REQ-039 Y=16, ly=15 -> obj_size=1 gives row 15; obj_size=0 gives no hit.
REQ-040 bg_map=1, scx=0x10, scy=0x0A, ly=0, tile_data=0, tile byte 0x00 -> addresses 0x1C22, 0x1004, 0x1005.
REQ-041 Same case with tile_data=1 -> addresses 0x1C22, 0x0004, 0x0005.
REQ-042 Hold row_ready=0 for 5 cycles at the first push -> row_valid and row data held and ppu_addr frozen; after 21 transfers the block reaches DONE with enables 0.
REQ-043 line_start during tile 5, then separately reset during OAM_SCAN -> restart with ppu_addr=0, sprite_count=0 and row_valid=0; after reset, all outputs are 0 and the block stays IDLE.
